// File: rtl/crc16_rx_checker.sv
// CRC-16 (poly 0x8005, init 0, MSB first) receive-side frame checker.
// Frames carry data bytes followed by the CRC high byte then low byte. An
// intact frame leaves a zero residue. A verdict is published one cycle after
// the eof byte as a done pulse plus one held flag.
module crc16_rx_checker #(
    parameter int MIN_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic [7:0]  din,
    input  logic        sof,
    input  logic        eof,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] frame_len,
    output logic [15:0] residue
);

    typedef enum logic [1:0] {IDLE, RECV, VERDICT} state_t;

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    state_t state;

    // One byte through the CRC register, bit 7 first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ 16'h8005;
            else              r = r << 1;
        end
        return r;
    endfunction

    logic        start;     // sof byte: (re)start a frame from any state
    logic        cont;      // ordinary byte inside a frame
    logic        fin;       // this byte closes the frame
    logic [15:0] nres;
    logic [15:0] nlen;
    logic        short_frame;

    // Next-byte datapath: a sof byte restarts from init, others extend the frame.
    always_comb begin
        start       = din_valid && sof;
        cont        = din_valid && !sof && (state == RECV);
        fin         = (start || cont) && eof;
        nres        = start ? crc_step(16'h0000, din) : crc_step(residue, din);
        nlen        = start ? 16'd1
                    : ((frame_len == 16'hFFFF) ? frame_len : frame_len + 16'd1);
        short_frame = (nlen < MIN_LEN_W);
    end

    // Frame FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            frame_len <= 16'h0000;
            residue   <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (start || cont) begin
                residue   <= nres;
                frame_len <= nlen;
            end
            if (start) begin
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
                len_err <= 1'b0;
            end
            if (fin) begin
                // Verdict is computed from the post-byte values so it is
                // visible during the single VERDICT cycle.
                state   <= VERDICT;
                busy    <= 1'b0;
                done    <= 1'b1;
                len_err <= short_frame;
                crc_err <= !short_frame && (nres != 16'h0000);
                crc_ok  <= !short_frame && (nres == 16'h0000);
            end else if (start || cont) begin
                state <= RECV;
                busy  <= 1'b1;
            end else if (state == VERDICT) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_crc16_rx_checker.sv
// Bench for crc16_rx_checker: a table of frames with expected verdicts feeds a
// scoreboard queue; a negedge monitor pops an entry on every done pulse.
// Hand sequences cover abort, reset mid-frame, flag hold and length saturation.
module tb_crc16_rx_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        sof = 1'b0;
    logic        eof = 1'b0;
    logic        busy, done, crc_ok, crc_err, len_err;
    logic [15:0] frame_len, residue;

    int n_tests = 0;
    int n_fail  = 0;

    crc16_rx_checker #(.MIN_LEN(3)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof), .eof(eof),
        .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
        .frame_len(frame_len), .residue(residue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [16];
        int          n;
        bit          gaps;
        bit          ok, cerr, lerr;
        logic [15:0] len;
    } vec_t;

    typedef struct {
        bit          ok, cerr, lerr;
        logic [15:0] len;
        logic [15:0] res;
        string       name;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Bit-serial reference CRC, written from the polynomial definition.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[7-i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    // Byte sampled with eof on the previous rising edge, for the latency check.
    logic last_eof = 1'b0;
    always @(posedge clk) last_eof <= din_valid & eof;

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            check("done_latency", 32'(last_eof), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, ".crc_ok"},    32'(crc_ok),    32'(e.ok));
                check({e.name, ".crc_err"},   32'(crc_err),   32'(e.cerr));
                check({e.name, ".len_err"},   32'(len_err),   32'(e.lerr));
                check({e.name, ".frame_len"}, 32'(frame_len), 32'(e.len));
                check({e.name, ".residue"},   32'(residue),   32'(e.res));
            end
        end
    end

    task automatic drive(input bit v, input bit s, input bit e, input logic [7:0] d);
        @(negedge clk);
        din_valid = v; sof = s; eof = e; din = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int idx);
        exp_t        e;
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < vecs[idx].n; i++) begin
            r = ref_crc(r, vecs[idx].b[i]);
            if (vecs[idx].gaps) begin
                // Gap cycles carry junk on sof/eof/din that must be ignored.
                for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                    drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            end
            if (i == vecs[idx].n - 1) begin
                e.ok = vecs[idx].ok; e.cerr = vecs[idx].cerr; e.lerr = vecs[idx].lerr;
                e.len = vecs[idx].len; e.res = r; e.name = $sformatf("vec%0d", idx);
                sb.push_back(e);
            end
            drive(1'b1, i == 0, i == vecs[idx].n - 1, vecs[idx].b[i]);
        end
    endtask

    task automatic set_check_str(input int idx, input bit gaps);
        string s;
        s = "123456789";
        for (int i = 0; i < 9; i++) vecs[idx].b[i] = s[i];
        vecs[idx].b[9] = 8'hFE; vecs[idx].b[10] = 8'hE8;
        vecs[idx].n = 11; vecs[idx].gaps = gaps;
        vecs[idx].ok = 1; vecs[idx].cerr = 0; vecs[idx].lerr = 0; vecs[idx].len = 16'd11;
    endtask

    initial begin
        exp_t        e;
        logic [15:0] c;
        #100000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [15:0] c;

        // 0: check string good; 1: last byte corrupted; 2: good with gaps
        set_check_str(0, 0);
        set_check_str(1, 0); vecs[1].b[10] = 8'hE9; vecs[1].ok = 0; vecs[1].cerr = 1;
        set_check_str(2, 1);
        // 3: two zero bytes, too short
        vecs[3].b[0] = 8'h00; vecs[3].b[1] = 8'h00; vecs[3].n = 2; vecs[3].gaps = 0;
        vecs[3].ok = 0; vecs[3].cerr = 0; vecs[3].lerr = 1; vecs[3].len = 16'd2;
        // 4: single sof&eof byte
        vecs[4].b[0] = 8'h5A; vecs[4].n = 1; vecs[4].gaps = 0;
        vecs[4].ok = 0; vecs[4].cerr = 0; vecs[4].lerr = 1; vecs[4].len = 16'd1;
        // 5: minimum legal length, good CRC on one data byte
        c = ref_crc(16'h0000, 8'hA7);
        vecs[5].b[0] = 8'hA7; vecs[5].b[1] = c[15:8]; vecs[5].b[2] = c[7:0];
        vecs[5].n = 3; vecs[5].gaps = 1;
        vecs[5].ok = 1; vecs[5].cerr = 0; vecs[5].lerr = 0; vecs[5].len = 16'd3;
        // 6: minimum legal length, bad CRC
        vecs[6] = vecs[5]; vecs[6].b[2] = c[7:0] ^ 8'h01; vecs[6].gaps = 0;
        vecs[6].ok = 0; vecs[6].cerr = 1;
        // 7: two-byte frame with nonzero residue: length error wins
        vecs[7].b[0] = 8'h12; vecs[7].b[1] = 8'h34; vecs[7].n = 2; vecs[7].gaps = 0;
        vecs[7].ok = 0; vecs[7].cerr = 0; vecs[7].lerr = 1; vecs[7].len = 16'd2;

        // Reset state
        #1;
        check("rst.busy", 32'(busy), 0);      check("rst.done", 32'(done), 0);
        check("rst.crc_ok", 32'(crc_ok), 0);  check("rst.crc_err", 32'(crc_err), 0);
        check("rst.len_err", 32'(len_err), 0);
        check("rst.frame_len", 32'(frame_len), 0); check("rst.residue", 32'(residue), 0);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Table: frames back-to-back (next sof lands in the VERDICT cycle);
        // stray valid bytes without sof precede the gapped frame.
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                idle(2);
                for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 1'(s & 1), 8'($urandom));
                idle(1);
                check("stray.busy", 32'(busy), 0);
            end
            send_frame(k);
        end
        idle(3);

        // Flags hold after done; busy is low in IDLE.
        send_frame(1);
        idle(4);
        check("hold.crc_err", 32'(crc_err), 1); check("hold.done", 32'(done), 0);
        check("hold.busy", 32'(busy), 0);       check("hold.crc_ok", 32'(crc_ok), 0);

        // Abort: sof after 5 bytes of a frame restarts without a done.
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 8'(8'h30 + i));
        #1 check("abort.busy", 32'(busy), 1);
        send_frame(0);
        idle(3);

        // Reset mid-frame: outputs clear immediately, frame is discarded.
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, 8'(8'h41 + i));
        @(negedge clk);
        din_valid = 1'b0; rst = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 0);           check("midrst.done", 32'(done), 0);
        check("midrst.frame_len", 32'(frame_len), 0); check("midrst.residue", 32'(residue), 0);
        check("midrst.crc_ok", 32'(crc_ok), 0);
        idle(2);
        rst = 1'b1;
        send_frame(0);
        idle(3);

        // Length saturation: 65537 zero bytes give zero residue and len 0xFFFF.
        e.ok = 1; e.cerr = 0; e.lerr = 0; e.len = 16'hFFFF; e.res = 16'h0000; e.name = "sat";
        for (int i = 0; i < 65537; i++) begin
            if (i == 65536) sb.push_back(e);
            drive(1'b1, i == 0, i == 65536, 8'h00);
        end
        idle(3);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_rx_checker.md
CRC16_RX_CHECKER -- requirements
Module: crc16_rx_checker

Interface
- REQ-001: Parameter MIN_LEN, default 3: minimum legal frame length in bytes, CRC trailer included; legal range 3..65535.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately; release is sampled on clk).
- REQ-004: din_valid  input  1  din carries a frame byte this cycle.
- REQ-005: din  input  8  frame byte; MSB (bit 7) is the first bit on the line.
- REQ-006: sof  input  1  qualified by din_valid; marks the first byte of a frame.
- REQ-007: eof  input  1  qualified by din_valid; marks the last byte of a frame (CRC low byte).
- REQ-008: busy  output  1  high while a frame is being received (state RECV).
- REQ-009: done  output  1  single-cycle pulse when a frame verdict is published.
- REQ-010: crc_ok  output  1  verdict: residue zero and length legal; held until the next sof.
- REQ-011: crc_err  output  1  verdict: residue nonzero; held until the next sof.
- REQ-012: len_err  output  1  verdict: frame length below MIN_LEN; held until the next sof.
- REQ-013: frame_len  output  16  bytes accepted in the last or current frame, saturating at 0xFFFF.
- REQ-014: residue  output  16  CRC register contents; final residue after done.

Function
- REQ-015: CRC shall be CRC-16 poly 0x8005 (x^16+x^15+x^2+1), init 0x0000, no reflection, no final XOR, 8 bits per clock, MSB first.
- REQ-016: Frames shall be data bytes followed by the 2-byte CRC, high byte first; the residue over the whole frame shall be 0x0000 for an intact frame.
- REQ-017: The FSM shall have states IDLE, RECV and VERDICT; reset state IDLE.
- REQ-018: IDLE -> RECV on din_valid&sof: load residue = CRC(0x0000, din), set frame_len=1, clear crc_ok/crc_err/len_err.
- REQ-019: In RECV, each din_valid byte shall update residue and increment frame_len; cycles with din_valid=0 are gaps and shall change nothing.
- REQ-020: RECV -> VERDICT on din_valid&eof, with that byte included in residue and frame_len.
- REQ-021: In VERDICT (exactly one cycle) the block shall assert done and set exactly one of crc_ok, crc_err or len_err, then return to IDLE.
- REQ-022: len_err shall take priority over crc_err when frame_len < MIN_LEN.
- REQ-023: sof&eof on the same valid byte shall be a 1-byte frame and produce len_err (MIN_LEN>=3).
- REQ-024: sof in RECV shall abort the current frame without done and restart per REQ-018 with that byte.
- REQ-025: Valid bytes in IDLE without sof shall be ignored.
- REQ-026: Valid bytes in VERDICT shall be ignored, except that sof shall be accepted as in REQ-018 with the FSM going to RECV.
- REQ-027: Verdict latency shall be 1 cycle: done is asserted the cycle after the eof byte is sampled.
- REQ-028: frame_len shall saturate at 0xFFFF; the CRC shall keep updating.
- REQ-029: busy shall equal (state==RECV), registered.

Reset
- REQ-030: On rst=0: state=IDLE, residue=0x0000, frame_len=0, and busy, done, crc_ok, crc_err, len_err all 0.
- REQ-031: Reset mid-frame shall discard the frame without done; the first valid sof after release starts a new frame.

Verification
- REQ-032: ASCII "123456789" then 0xFE,0xE8 (sof on '1', eof on 0xE8), contiguous -> done 1 cycle after eof, crc_ok=1, residue=0x0000, frame_len=11.
- REQ-033: Same frame with last byte 0xE9 -> crc_err=1, crc_ok=0, residue!=0, frame_len=11.
- REQ-034: Same good frame with random din_valid gaps, plus stray valid bytes in IDLE -> identical result to REQ-032.
- REQ-035: 2-byte frame 0x00,0x00 -> len_err=1, crc_ok=0, crc_err=0, frame_len=2; a single sof&eof byte -> len_err=1, frame_len=1.
- REQ-036: New sof after 5 bytes of a frame, then a full good frame -> no done for the aborted frame, crc_ok=1, frame_len=11.
- REQ-037: rst pulsed low mid-frame -> all outputs 0 at once; a following good frame -> crc_ok=1.
